// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches take priority over CPU accesses, but a started
// CPU access always runs to completion. RAM-side and result outputs are all registered.
module vram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_slot,
  input  logic [12:0] vga_addr,
  output logic [7:0]  vga_data,
  output logic        vga_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout,
  output logic        overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StVgaRd,
    StVgaLatch,
    StCpuAcc,
    StCpuWait,
    StCpuDone
  } state_e;

  state_e      state_q, state_d;
  logic        pend_q;
  logic [12:0] pend_addr_q;
  logic        acc_we_q;
  logic        vga_due;
  logic [12:0] fetch_addr;

  // A fresh slot in the same cycle supersedes the older pending address.
  assign vga_due    = pend_q | vga_slot;
  assign fetch_addr = vga_slot ? vga_addr : pend_addr_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vga_due) begin
          state_d = StVgaRd;
        end else if (cpu_req) begin
          state_d = StCpuAcc;
        end else begin
          state_d = StIdle;
        end
      end
      StVgaRd:    state_d = StVgaLatch;
      StVgaLatch: state_d = StIdle;
      StCpuAcc:   state_d = StCpuWait;
      StCpuWait:  state_d = StCpuDone;
      // cpu_req is still high here (ack not yet seen), so only a fetch may follow directly.
      StCpuDone:  state_d = vga_due ? StVgaRd : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      acc_we_q    <= 1'b0;
      vga_data    <= '0;
      vga_valid   <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_dout    <= '0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_din     <= '0;
      overrun     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vga_valid <= (state_q == StVgaLatch);
      cpu_ack   <= (state_q == StCpuWait);
      overrun   <= overrun | (vga_slot & pend_q);
      ram_we    <= 1'b0;

      if (state_q == StVgaLatch) begin
        vga_data <= ram_dout;
      end
      if ((state_q == StCpuWait) && !acc_we_q) begin
        cpu_dout <= ram_dout;
      end

      if (state_d == StVgaRd) begin
        pend_q   <= 1'b0;
        ram_addr <= fetch_addr;
      end else if (vga_slot) begin
        pend_q      <= 1'b1;
        pend_addr_q <= vga_addr;
      end

      if (state_d == StCpuAcc) begin
        ram_addr <= cpu_addr;
        ram_we   <= cpu_we;
        ram_din  <= cpu_din;
        acc_we_q <= cpu_we;
      end
    end
  end

endmodule
